// File: rtl/rv_ahb_sram_slave.sv
// AHB-style SRAM responder: serves pipelined address/data-phase transfers from a
// word-organised array, stretches each in-range data phase by WAIT_STATES cycles,
// and answers out-of-window addresses with a two-cycle ERROR response.
module rv_ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [31:0] ABus,
  input  logic [1:0]  TRANSBus,
  input  logic        WRITEBus,
  input  logic [1:0]  SIZEBus,
  input  logic [31:0] WDBus,
  output logic [31:0] RDBus,
  output logic        RDYBus,
  output logic        RESPBus
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;

  logic [31:0]     w_offset;
  logic            w_in_range;
  logic            w_rdy;
  logic            w_accept;
  logic            w_commit;
  logic [3:0]      w_be;

  // Captured address-phase control for the data phase in flight.
  logic [AW-1:0]   r_idx_p1;
  logic [1:0]      r_lane_p1;
  logic [1:0]      r_size_p1;
  logic            r_write_p1;

  logic [31:0]     r_mem [DEPTH_WORDS];

  // Byte lanes touched by a write of the given size at the given low address bits.
  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   lane_enables = 4'b0001 << lane;
      2'b01:   lane_enables = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  // Window decode and address-phase accept. Offset wraps for addresses below
  // BASE_ADDR, so a single unsigned compare covers both sides of the window.
  assign w_offset   = ABus - BASE_ADDR;
  assign w_in_range = (w_offset < SPAN);
  assign w_rdy      = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign w_accept   = sel & TRANSBus[1] & w_rdy;

  assign RDYBus     = w_rdy;
  assign RESPBus    = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign w_commit   = (r_state == S_DATA) && r_write_p1;
  assign w_be       = lane_enables(r_size_p1, r_lane_p1);

  // Read data straight from the array during the final cycle of a read.
  assign RDBus      = (r_state == S_DATA && !r_write_p1) ? r_mem[r_idx_p1] : 32'h0;

  // State and wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: any cycle with RDYBus high may accept the next transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = S_DATA;
      end
      S_ERR1: begin
        w_state_nxt = S_ERR2;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
        if (w_accept) begin
          if (!w_in_range) begin
            w_state_nxt = S_ERR1;
          end else if (WS == 4'd0) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS;
          end
        end
      end
    endcase
  end

  // ---- address phase -> data phase boundary ----
  // Capture address, direction and size on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx_p1   <= '0;
      r_lane_p1  <= 2'b00;
      r_size_p1  <= 2'b00;
      r_write_p1 <= 1'b0;
    end else if (w_accept) begin
      r_idx_p1   <= w_offset[AW+1:2];
      r_lane_p1  <= w_offset[1:0];
      r_size_p1  <= SIZEBus;
      r_write_p1 <= WRITEBus;
    end
  end

  // ---- data phase -> array boundary ----
  // Commit enabled write lanes at the edge that closes the DATA cycle.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx_p1][8*b +: 8] <= WDBus[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/rv_ahb_sram_slave.md
Name: rv_ahb_sram_slave

Overview:
AHB-style responder that sits on the arbitrated bus output (ABus/TRANSBus/WDBus side) and serves the initiators' requests from a word-organised on-chip SRAM. It does the address phase / data phase pipelining and inserts a programmable number of wait states by holding RDYBus low. It supports byte, halfword and word writes, and returns a two-cycle error response for addresses outside its window. It is the responder counterpart of the fetch/AHB-interface/arbiter initiator chain.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of SRAM word 0; must be aligned to DEPTH_WORDS*4.
DEPTH_WORDS, 1024, number of 32-bit words; power of two, 2..65536.
WAIT_STATES, 1, wait cycles inserted per accepted NONSEQ/SEQ transfer; 0..15.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
sel  in  1  slave select from the address decoder; qualifies the address phase.
ABus  in  32  address-phase byte address.
TRANSBus  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
WRITEBus  in  1  1 = write, 0 = read (address phase).
SIZEBus  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
WDBus  in  32  write data, valid during the data phase.
RDBus  out  32  read data, valid when RDYBus=1 in a read data phase.
RDYBus  out  1  data-phase complete / address phase may advance.
RESPBus  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset, asynchronous: state=IDLE, RDYBus=1, RESPBus=0, RDBus=0, captured address/control cleared, wait counter=0. SRAM contents are not reset. A reset in the middle of a transfer discards any pending write.
- Address-phase accept: sel & TRANSBus[1] & RDYBus at a clk edge. On accept, capture addr, write and size.
  - Offset = addr - BASE_ADDR. The access is in range when offset < DEPTH_WORDS*4. Word index = offset[log2(DEPTH)+1:2].
- IDLE or BUSY transfers, or sel=0: nothing is captured. The following data phase completes at once with RDYBus=1, RESPBus=0, RDBus=0.
- FSM states:
  - IDLE (no pending data phase).
  - WAIT (counter>0).
  - DATA (final cycle).
  - ERR1 and ERR2.
- FSM transitions:
  - Accept in range, WAIT_STATES=0 -> DATA.
  - Accept in range, WAIT_STATES>0 -> WAIT with counter=WAIT_STATES.
  - WAIT: counter decrements each cycle; at counter==1 go to DATA.
  - DATA: with a new accept -> DATA or WAIT as above; otherwise -> IDLE.
  - Accept out of range -> ERR1 -> ERR2 -> (same accept rules as DATA).
- Outputs per state:
  - IDLE: RDYBus=1, RESPBus=0.
  - WAIT: RDYBus=0, RESPBus=0.
  - DATA: RDYBus=1, RESPBus=0.
  - ERR1: RDYBus=0, RESPBus=1.
  - ERR2: RDYBus=1, RESPBus=1.
- Latency: the data phase lasts WAIT_STATES+1 cycles in range and exactly 2 cycles on error.
- Read data: RDBus = mem[index], combinational from the array while in DATA with a read captured; otherwise 0. Full word returned regardless of size.
- Write commit: at the clk edge ending DATA (RDYBus=1). Byte enables:
  - byte: lane addr[1:0].
  - halfword: lanes {addr[1],0} and {addr[1],1}.
  - word: all 4 lanes, low address bits ignored.
  - Only enabled lanes of WDBus are written.
- Writes in ERR1/ERR2 are discarded. RDBus=0 during error.
- Back-to-back write then read to the same word: the write commits at the edge where the read address is accepted, so the read data phase returns the new data. No forwarding path is needed.
- While RDYBus=0 the slave ignores ABus/TRANSBus; the initiator holds them.
- A new accept during ERR2 or DATA is legal (pipelined).

Test Plan:
1. rst=1 then released, WAIT_STATES=1, DATA idle -> RDYBus=1, RESPBus=0, RDBus=0; TRANS=IDLE with sel=1 keeps RDYBus=1 every cycle.
2. NONSEQ word write to 0x10 with WDBus=32'hDEADBEEF, then NONSEQ read 0x10 -> write data phase has RDYBus low 1 cycle, then high; read returns 32'hDEADBEEF in its RDYBus=1 cycle.
3. Byte write 0xA5 to 0x13, then halfword write 0x1234 to 0x10 -> word read of 0x10 returns 32'hA5AD1234 (from the 32'hDEADBEEF preload).
4. WAIT_STATES=3, back-to-back SEQ reads of 0x0 and 0x4 -> each data phase has exactly 3 RDYBus=0 cycles; the second address is accepted only on the RDYBus=1 cycle.
5. Write to BASE_ADDR+DEPTH_WORDS*4 -> ERR1 (RDY=0, RESP=1), then ERR2 (RDY=1, RESP=1); a later read of word 0 is unchanged.
6. Assert rst during WAIT of a write to 0x20 (old value 0) -> RDYBus=1 asynchronously; a subsequent read of 0x20 returns 0.
